// File: rtl/line_capture_pkg.sv
// Shared types and helpers for the line_capture active-video stage.
// Holds the capture state enum, the pixel type and the clamp-subtract.
package line_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PORCH,
        CAPTURE,
        DONE
    } state_t;

    typedef logic [5:0] pix_t;

    function automatic pix_t clamp_sub(input pix_t a, input pix_t b);
        logic signed [6:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[6] ? '0 : pix_t'(d[5:0]);
    endfunction

endpackage

// File: rtl/line_capture_ram.sv
// Ping-pong line store: two banks of PIXELS x 6 bits, one write port,
// one read port with a registered output so it maps onto block RAM.
module line_ram
    import line_capture_pkg::*;
#(
    parameter int PIXELS = 512,
    parameter int AW     = $clog2(PIXELS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  pix_t          wr_data,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output pix_t          rd_data
);

    pix_t mem [2**(AW+1)];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
        rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/line_capture.sv
// Active-video line capture into a ping-pong buffer with a random-access read port.
// Define LINE_CAPTURE_AVG_EN to average each decimation window instead of point sampling.
module line_capture
    import line_capture_pkg::*;
#(
    parameter int PIXELS    = 512,
    parameter int DECIM     = 2,
    parameter int LINES_MAX = 312
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ce,
    input  logic [5:0]                 cvbs,
    input  logic                       hsync,
    input  logic                       vsync,
    input  logic                       porch,
    input  logic [5:0]                 blacklevel,
    input  logic [$clog2(PIXELS)-1:0]  rd_addr,
    output logic [5:0]                 rd_data,
    output logic                       line_ready,
    output logic [8:0]                 line_index,
    output logic [$clog2(PIXELS):0]    pix_count,
    output logic                       short_line
);

    localparam int AW = $clog2(PIXELS);
    localparam int DW = $clog2(DECIM);
    localparam int CW = (DW > 0) ? DW : 1;

    localparam logic [AW:0]   PIX_END = (AW+1)'(PIXELS);
    localparam logic [CW-1:0] WIN_END = CW'(DECIM - 1);
    localparam logic [8:0]    LCNT_MAX = 9'(LINES_MAX - 1);

    state_t        state;
    state_t        state_n;
    logic          hsync_q;
    logic          vsync_q;
    logic          porch_q;
    logic          wbank;
    logic [8:0]    lcnt;
    logic [CW-1:0] dcnt;
    logic [AW:0]   wcnt;
    logic          rd_zero;
    pix_t          ram_q;

    logic          hs_fall;
    logic          vs_fall;
    logic          porch_fall;
    logic          win_end;
    logic          wr_en;
    logic [AW:0]   wcnt_inc;
    logic [AW:0]   wcnt_eff;
    logic          line_end;
    logic          swap;
    logic          clr;
    pix_t          sample;
    pix_t          wr_data;

    assign hs_fall    = ce & hsync_q & ~hsync;
    assign vs_fall    = ce & vsync_q & ~vsync;
    assign porch_fall = ce & porch_q & ~porch;

    assign win_end  = (dcnt == WIN_END);
    assign wr_en    = ce & (state == CAPTURE) & win_end;
    assign wcnt_inc = wcnt + 1'b1;
    // A write landing on the hsync-fall tick belongs to the closing line
    assign wcnt_eff = wr_en ? wcnt_inc : wcnt;
    assign line_end = hs_fall & (state != IDLE);
    assign swap     = line_end & (wcnt_eff != '0);
    assign clr      = hs_fall | vs_fall
                    | ((state == WAIT_PORCH) & porch_fall);

`ifdef LINE_CAPTURE_AVG_EN
    localparam int SW = 6 + DW;

    logic [SW-1:0] acc;
    logic [SW-1:0] sum;

    assign sum    = acc + SW'(cvbs);
    assign sample = pix_t'(sum >> DW);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (ce) begin
            if (clr || (state == CAPTURE && win_end)) begin
                acc <= '0;
            end else if (state == CAPTURE) begin
                acc <= sum;
            end
        end
    end
`else
    assign sample = cvbs;
`endif

    assign wr_data = clamp_sub(sample, blacklevel);

    always_comb begin
        state_n = state;
        if (vs_fall) begin
            state_n = IDLE;
        end else if (hs_fall) begin
            state_n = WAIT_PORCH;
        end else begin
            unique case (state)
                WAIT_PORCH: if (porch_fall) state_n = CAPTURE;
                CAPTURE:    if (wr_en && wcnt_inc == PIX_END) state_n = DONE;
                default:    state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            porch_q    <= 1'b0;
            wbank      <= 1'b0;
            lcnt       <= '0;
            dcnt       <= '0;
            wcnt       <= '0;
            line_ready <= 1'b0;
            line_index <= '0;
            pix_count  <= '0;
            short_line <= 1'b0;
        end else begin
            line_ready <= 1'b0;
            if (ce) begin
                hsync_q <= hsync;
                vsync_q <= vsync;
                porch_q <= porch;

                if (clr) begin
                    dcnt <= '0;
                    wcnt <= '0;
                end else if (state == CAPTURE) begin
                    dcnt <= win_end ? '0 : dcnt + 1'b1;
                    if (win_end) wcnt <= wcnt_inc;
                end

                if (swap) begin
                    wbank      <= ~wbank;
                    line_ready <= 1'b1;
                    line_index <= lcnt;
                    pix_count  <= wcnt_eff;
                    short_line <= (wcnt_eff != PIX_END);
                end

                if (vs_fall) begin
                    lcnt <= '0;
                end else if (line_end && lcnt != LCNT_MAX) begin
                    lcnt <= lcnt + 1'b1;
                end
            end
        end
    end

    // Out-of-range reads and the reset clock both return zero
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_zero <= 1'b1;
        end else begin
            rd_zero <= ({1'b0, rd_addr} >= PIX_END);
        end
    end

    assign rd_data = rd_zero ? 6'd0 : ram_q;

    line_ram #(
        .PIXELS (PIXELS),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .wr_bank (wbank),
        .wr_addr (wcnt[AW-1:0]),
        .wr_data (wr_data),
        .rd_bank (~wbank),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

endmodule
